// File: rtl/tm1638_frame_encoder_if.sv
// Byte-stream link from the frame encoder to the TM1638 serial driver.
// byte_last marks the final byte of one STB group.
interface tm1638_frame_encoder_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;

  modport master (output byte_data, output byte_valid, output byte_last, input byte_ready);
  modport slave  (input byte_data, input byte_valid, input byte_last, output byte_ready);
endinterface

// File: rtl/tm1638_frame_encoder.sv
// Snapshots digits/dp/LEDs/brightness on update and streams one 19-byte TM1638 refresh frame:
// data cmd, address cmd, 8 x (segment, LED) pairs, display-control cmd.
module tm1638_frame_encoder #(
  parameter int DIGITS   = 8,
  parameter int HEX_MODE = 0,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  update,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     leds_in,
  input  logic [2:0]            bright,
  input  logic                  disp_on,
  output logic                  busy,
  tm1638_frame_encoder_if.master bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CMD_DATA = 3'd1;
  localparam logic [2:0] CMD_ADDR = 3'd2;
  localparam logic [2:0] SEG      = 3'd3;
  localparam logic [2:0] LED      = 3'd4;
  localparam logic [2:0] CMD_DISP = 3'd5;

  logic [2:0]          state;
  logic [2:0]          pos;
  logic [2:0]          pos_nx;
  logic                pending;
  logic                xfer;
  logic                take;
  logic [4*DIGITS-1:0] digits_s;
  logic [DIGITS-1:0]   dp_s;
  logic [DIGITS-1:0]   leds_s;
  logic [2:0]          bright_s;
  logic                disp_on_s;
  logic [3:0]          nib [8];
  logic [7:0]          dps;
  logic [7:0]          leds8;
  logic [7:0]          seg_byte [8];
  logic [7:0]          ctrl_byte;
  logic                lead;

  function automatic logic [7:0] seg_of(input logic [3:0] n, input logic dp);
    logic [7:0] s;
    case (n)
      4'd0: s = 8'hFC;
      4'd1: s = 8'h60;
      4'd2: s = 8'hDA;
      4'd3: s = 8'hF2;
      4'd4: s = 8'h66;
      4'd5: s = 8'hB6;
      4'd6: s = 8'hBE;
      4'd7: s = 8'hE0;
      4'd8: s = 8'hFE;
      4'd9: s = 8'hF6;
      4'hA: s = (HEX_MODE != 0) ? 8'hEE : 8'h01;
      4'hB: s = (HEX_MODE != 0) ? 8'h3E : 8'h01;
      4'hC: s = (HEX_MODE != 0) ? 8'h9C : 8'h01;
      4'hD: s = (HEX_MODE != 0) ? 8'h7A : 8'h01;
      4'hE: s = (HEX_MODE != 0) ? 8'h9E : 8'h01;
      default: s = (HEX_MODE != 0) ? 8'h8E : 8'h01;
    endcase
    return s | {7'b0, dp};
  endfunction

  // Positions beyond DIGITS read as blank zeros so the frame is always 8 pairs long.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pos
    if (gi < DIGITS) begin : g_act
      assign nib[gi]   = digits_s[4*gi +: 4];
      assign dps[gi]   = dp_s[gi];
      assign leds8[gi] = leds_s[gi];
    end else begin : g_pad
      assign nib[gi]   = 4'h0;
      assign dps[gi]   = 1'b0;
      assign leds8[gi] = 1'b0;
    end
  end

  // lead stays true only while every digit so far is a plain zero without dp.
  always_comb begin
    lead = (BLANK_LZ != 0);
    for (int i = 0; i < 8; i++) begin
      lead = lead && (nib[i] == 4'h0) && !dps[i] && (i != DIGITS - 1);
      seg_byte[i] = ((i >= DIGITS) || lead) ? 8'h00 : seg_of(nib[i], dps[i]);
    end
  end

  assign ctrl_byte = disp_on_s ? {5'b10001, bright_s} : 8'h80;
  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign pos_nx    = pos + 3'd1;
  assign take      = ((state == IDLE) && update) ||
                     ((state == CMD_DISP) && xfer && (pending || update));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits_s  <= '0;
      dp_s      <= '0;
      leds_s    <= '0;
      bright_s  <= 3'd0;
      disp_on_s <= 1'b0;
    end else if (take) begin
      digits_s  <= digits_in;
      dp_s      <= dp_in;
      leds_s    <= leds_in;
      bright_s  <= bright;
      disp_on_s <= disp_on;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      pos            <= 3'd0;
      pending        <= 1'b0;
      busy           <= 1'b0;
      bus.byte_valid <= 1'b0;
      bus.byte_data  <= 8'h00;
      bus.byte_last  <= 1'b0;
    end else begin
      if (take)
        pending <= 1'b0;
      else if (update && (state != IDLE))
        pending <= 1'b1;

      case (state)
        IDLE: if (update) begin
          state          <= CMD_DATA;
          busy           <= 1'b1;
          bus.byte_valid <= 1'b1;
          bus.byte_data  <= 8'h40;
          bus.byte_last  <= 1'b1;
        end
        CMD_DATA: if (xfer) begin
          state         <= CMD_ADDR;
          bus.byte_data <= 8'hC0;
          bus.byte_last <= 1'b0;
        end
        CMD_ADDR: if (xfer) begin
          state         <= SEG;
          bus.byte_data <= seg_byte[pos];
          bus.byte_last <= 1'b0;
        end
        SEG: if (xfer) begin
          state         <= LED;
          bus.byte_data <= {7'b0, leds8[pos]};
          bus.byte_last <= (pos == 3'd7);
        end
        LED: if (xfer) begin
          pos <= pos_nx;
          if (pos == 3'd7) begin
            state         <= CMD_DISP;
            bus.byte_data <= ctrl_byte;
            bus.byte_last <= 1'b1;
          end else begin
            state         <= SEG;
            bus.byte_data <= seg_byte[pos_nx];
            bus.byte_last <= 1'b0;
          end
        end
        CMD_DISP: if (xfer) begin
          // A queued request restarts immediately, so busy never drops between frames.
          if (pending || update) begin
            state         <= CMD_DATA;
            bus.byte_data <= 8'h40;
            bus.byte_last <= 1'b1;
          end else begin
            state          <= IDLE;
            busy           <= 1'b0;
            bus.byte_valid <= 1'b0;
            bus.byte_data  <= 8'h00;
            bus.byte_last  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_frame_encoder.sv
// Drives two encoder variants (decimal with blanking, hex without blanking) from shared inputs
// and compares their byte streams against a frame model built from the segment/frame rules.
module tb_tm1638_frame_encoder;
  logic        clk = 1'b0;
  logic        rst_n, update, disp_on, ready, rand_ready;
  logic [31:0] digits;
  logic [7:0]  dp, leds;
  logic [2:0]  bright;
  logic        busy0, busy1;
  int          total = 0;
  int          bad = 0;
  logic [8:0]  got0[$], got1[$], exp0[$], exp1[$];

  always #5 clk = ~clk;

  tm1638_frame_encoder_if if0 ();
  tm1638_frame_encoder_if if1 ();
  assign if0.byte_ready = ready;
  assign if1.byte_ready = ready;

  tm1638_frame_encoder #(.DIGITS(8), .HEX_MODE(0), .BLANK_LZ(1)) u_dec (
    .clk(clk), .rst_n(rst_n), .update(update), .digits_in(digits), .dp_in(dp),
    .leds_in(leds), .bright(bright), .disp_on(disp_on), .busy(busy0), .bus(if0.master));

  tm1638_frame_encoder #(.DIGITS(8), .HEX_MODE(1), .BLANK_LZ(0)) u_hex (
    .clk(clk), .rst_n(rst_n), .update(update), .digits_in(digits), .dp_in(dp),
    .leds_in(leds), .bright(bright), .disp_on(disp_on), .busy(busy1), .bus(if1.master));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] dec_seg(input logic [3:0] n, input bit hex);
    case (n)
      4'd0: return 8'hFC;  4'd1: return 8'h60;  4'd2: return 8'hDA;  4'd3: return 8'hF2;
      4'd4: return 8'h66;  4'd5: return 8'hB6;  4'd6: return 8'hBE;  4'd7: return 8'hE0;
      4'd8: return 8'hFE;  4'd9: return 8'hF6;
      4'hA: return hex ? 8'hEE : 8'h01;  4'hB: return hex ? 8'h3E : 8'h01;
      4'hC: return hex ? 8'h9C : 8'h01;  4'hD: return hex ? 8'h7A : 8'h01;
      4'hE: return hex ? 8'h9E : 8'h01;  default: return hex ? 8'h8E : 8'h01;
    endcase
  endfunction

  // Byte k of the frame for the current inputs, as {last, data}.
  function automatic logic [8:0] fbyte(input int k, input bit hex, input bit blank);
    int i, first;
    logic [3:0] n;
    if (k == 0) return {1'b1, 8'h40};
    if (k == 1) return {1'b0, 8'hC0};
    if (k == 18) return {1'b1, disp_on ? (8'h88 | {5'b0, bright}) : 8'h80};
    i = (k - 2) / 2;
    if (k % 2 == 1) return {(i == 7), 7'b0, leds[i]};
    first = 7;
    for (int j = 7; j >= 0; j--)
      if (digits[4*j +: 4] != 4'h0 || dp[j]) first = j;
    if (blank && i < first) return 9'h000;
    n = digits[4*i +: 4];
    return {1'b0, dec_seg(n, hex) | {7'b0, dp[i]}};
  endfunction

  task automatic push_exp();
    for (int k = 0; k < 19; k++) begin
      exp0.push_back(fbyte(k, 1'b0, 1'b1));
      exp1.push_back(fbyte(k, 1'b1, 1'b0));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic check_one(input string tag, input logic [8:0] g[$], input logic [8:0] e[$],
                           input int n);
    chk({tag, "_len"}, 32'(g.size()), 32'(n));
    for (int k = 0; k < n && k < g.size() && k < e.size(); k++)
      chk($sformatf("%s_b%0d", tag, k), 32'(g[k]), 32'(e[k]));
  endtask

  task automatic check_frames(input string tag, input int n);
    check_one({tag, "_dec"}, got0, exp0, n);
    check_one({tag, "_hex"}, got1, exp1, n);
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 400; c++) begin
      if (!busy0 && !busy1) break;
      cycle();
    end
    chk({tag, "_idle"}, {30'd0, busy0, busy1}, 32'd0);
  endtask

  task automatic run_frame(input string tag);
    push_exp();
    update = 1'b1;
    cycle();
    update = 1'b0;
    wait_idle(tag);
    check_frames(tag, 19);
  endtask

  task automatic randomize_inputs();
    digits  = $urandom << (4 * $urandom_range(0, 8));
    dp      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
    leds    = 8'($urandom);
    bright  = 3'($urandom);
    disp_on = 1'($urandom);
  endtask

  // Stream monitor: records every transfer and checks stalled bytes hold still.
  initial begin
    logic       stall0, stall1;
    logic [8:0] hold0, hold1;
    stall0 = 1'b0; stall1 = 1'b0; hold0 = '0; hold1 = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (stall0) chk("stall_dec", {22'd0, if0.byte_valid, if0.byte_last, if0.byte_data},
                        {22'd0, 1'b1, hold0});
        if (stall1) chk("stall_hex", {22'd0, if1.byte_valid, if1.byte_last, if1.byte_data},
                        {22'd0, 1'b1, hold1});
        if (if0.byte_valid && ready) got0.push_back({if0.byte_last, if0.byte_data});
        if (if1.byte_valid && ready) got1.push_back({if1.byte_last, if1.byte_data});
      end
      stall0 = (rst_n === 1'b1) && if0.byte_valid && !ready;
      stall1 = (rst_n === 1'b1) && if1.byte_valid && !ready;
      hold0  = {if0.byte_last, if0.byte_data};
      hold1  = {if1.byte_last, if1.byte_data};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; update = 1'b0; ready = 1'b1; rand_ready = 1'b0;
    digits = '0; dp = '0; leds = '0; bright = '0; disp_on = 1'b1;
    repeat (3) cycle();
    chk("rst_busy",  32'(busy0), 32'd0);
    chk("rst_valid", 32'(if0.byte_valid), 32'd0);
    chk("rst_data",  32'(if0.byte_data), 32'h00);
    chk("rst_last",  32'(if0.byte_last), 32'd0);
    rst_n = 1'b1;
    repeat (2) cycle();
    chk("idle_valid", {30'd0, if0.byte_valid, if1.byte_valid}, 32'd0);

    // Ascending digits, first-byte latency
    digits = 32'h8765_4321; dp = 8'h00; leds = 8'h00; bright = 3'd5; disp_on = 1'b1;
    push_exp();
    update = 1'b1;
    cycle();
    update = 1'b0;
    chk("t1_busy",  32'(busy0), 32'd1);
    chk("t1_valid", 32'(if0.byte_valid), 32'd1);
    chk("t1_data",  32'(if0.byte_data), 32'h40);
    chk("t1_last",  32'(if0.byte_last), 32'd1);
    wait_idle("t1");
    check_frames("t1", 19);

    // Leading-zero blanking
    digits = 32'h0010_0000; leds = 8'hA5;
    run_frame("t2_lz");
    digits = 32'h0; dp = 8'h00;
    run_frame("t2_zero");
    digits = 32'h0; dp = 8'h04;
    run_frame("t2_dp");

    // Invalid / hex nibble and display off
    digits = 32'h0000_B000; dp = 8'h00; disp_on = 1'b0; bright = 3'd7;
    run_frame("t5");

    // Random inputs under random back-pressure
    rand_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      randomize_inputs();
      run_frame($sformatf("t3_%0d", f));
    end

    // Requests during a frame coalesce into one restart using the restart-time inputs
    randomize_inputs();
    push_exp();
    update = 1'b1;
    cycle();
    update = 1'b0;
    repeat (3) cycle();
    for (int p = 0; p < 3; p++) begin
      update = 1'b1;
      cycle();
      update = 1'b0;
      cycle();
    end
    randomize_inputs();
    push_exp();
    for (int c = 0; c < 400 && got0.size() < 38; c++) begin
      chk("t4_busy", {30'd0, busy0, busy1}, 32'd3);
      cycle();
    end
    wait_idle("t4");
    check_frames("t4", 38);

    // Update coinciding with the final transfer restarts the frame
    rand_ready = 1'b0;
    cycle();
    randomize_inputs();
    push_exp();
    update = 1'b1;
    cycle();
    update = 1'b0;
    repeat (18) cycle();
    chk("t7_ctrl_last", 32'(if0.byte_last), 32'd1);
    randomize_inputs();
    push_exp();
    update = 1'b1;
    cycle();
    update = 1'b0;
    chk("t7_busy", 32'(busy0), 32'd1);
    chk("t7_data", 32'(if0.byte_data), 32'h40);
    wait_idle("t7");
    check_frames("t7", 38);

    // Reset while segment 4 is presented aborts the frame
    randomize_inputs();
    push_exp();
    update = 1'b1;
    cycle();
    update = 1'b0;
    repeat (10) cycle();
    chk("t6_seg4", 32'(if0.byte_data), 32'(exp0[10][7:0]));
    rst_n = 1'b0;
    cycle();
    chk("t6_valid", {30'd0, if0.byte_valid, if1.byte_valid}, 32'd0);
    chk("t6_busy",  {30'd0, busy0, busy1}, 32'd0);
    chk("t6_data",  32'(if0.byte_data), 32'h00);
    chk("t6_last",  32'(if0.byte_last), 32'd0);
    rst_n = 1'b1;
    cycle();
    check_frames("t6_abort", 10);
    repeat (4) cycle();
    chk("t6_quiet", 32'(got0.size() + got1.size()), 32'd0);
    randomize_inputs();
    run_frame("t6_fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
